// File: rtl/oppm_pkg.sv
// Enumerations shared across the OPPM link (transmit queue, receive framer).
package oppm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    GAP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_HUNT,
    RX_SYNC,
    RX_DATA
  } rx_state_e;

endpackage

// File: rtl/counter.sv
// Free-running up counter with synchronous clear; clear wins over enable.
// One cycle from enable to updated count; no backpressure.
module counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/packet_fifo.sv
// Circular packet buffer with combinational head; push/pop take effect on the next edge.
// Push ignored when full, pop ignored when empty; flush overrides both.
module packet_fifo #(
  parameter  int W     = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // A full queue never accepts, even when the head leaves in the same cycle.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/tx_packet_queue.sv
// Queues packets for the OPPM encoder and launches them with a minimum idle gap.
// enc_start can follow a push by one cycle; wr_ready drops when full or flushing.
module tx_packet_queue
  import oppm_pkg::*;
#(
  parameter int N_PKT  = 16,
  parameter int DEPTH  = 4,
  parameter int GAP_CT = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_PKT-1:0]           wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic                       flush,
  input  logic                       enc_avail,
  output logic                       enc_start,
  output logic [N_PKT-1:0]           enc_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int GCW      = (GAP_CT < 2) ? 1 : $clog2(GAP_CT);
  localparam int GAP_LAST = (GAP_CT == 0) ? 0 : GAP_CT - 1;

  tx_state_e      state;
  logic [GCW-1:0] gap_cnt;
  logic           push;
  logic           gap_done;
  logic           gap_clr;
  logic           gap_en;

  assign wr_ready = !full && !flush;
  assign push     = wr_valid && wr_ready;

  // The launch strobe doubles as the pop, so enc_data is the head being consumed.
  assign enc_start = (state == IDLE) && enc_avail && !empty && !flush;

  // The first available cycle in GAP counts as gap tick one.
  assign gap_done = enc_avail && (gap_cnt == GCW'(GAP_LAST));
  assign gap_clr  = (state == LAUNCH) && !enc_avail;
  assign gap_en   = (state == GAP) && enc_avail && !gap_done;

  packet_fifo #(
    .W     (N_PKT),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (enc_start),
    .flush     (flush),
    .push_data (wr_data),
    .head      (enc_data),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  counter #(
    .W (GCW)
  ) u_gap_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (gap_clr),
    .en    (gap_en),
    .cnt   (gap_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (enc_start) begin
            state <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (!enc_avail) begin
            state <= GAP;
          end
        end
        GAP: begin
          if (gap_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_packet_queue.sv
// Randomised and directed bench for tx_packet_queue against a queue-based launch model.
module tb_tx_packet_queue;

  localparam int N_PKT  = 16;
  localparam int DEPTH  = 4;
  localparam int GAP_CT = 3;
  localparam int THR    = (GAP_CT == 0) ? 1 : GAP_CT;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N_PKT-1:0]  wr_data = '0;
  logic              wr_valid = 1'b0;
  logic              flush = 1'b0;
  logic              enc_avail = 1'b0;
  logic              wr_ready;
  logic              enc_start;
  logic [N_PKT-1:0]  enc_data;
  logic [2:0]        count;
  logic              empty;
  logic              full;

  int checks = 0;
  int errors = 0;

  // Model: packet queue plus "encoder released" bookkeeping after each launch.
  logic [N_PKT-1:0] m_q[$];
  bit               m_free = 1'b1;
  bit               m_seen_low = 1'b0;
  int               m_hi = 0;

  always #5 clk = ~clk;

  tx_packet_queue #(
    .N_PKT  (N_PKT),
    .DEPTH  (DEPTH),
    .GAP_CT (GAP_CT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .flush     (flush),
    .enc_avail (enc_avail),
    .enc_start (enc_start),
    .enc_data  (enc_data),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  function automatic bit m_launch();
    return m_free && enc_avail && (m_q.size() != 0) && !flush;
  endfunction

  function automatic bit m_ready();
    return (m_q.size() < DEPTH) && !flush;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_update
    bit l;
    bit acc;
    if (!rst_n) begin
      m_q.delete();
      m_free     = 1'b1;
      m_seen_low = 1'b0;
      m_hi       = 0;
    end else begin
      l   = m_launch();
      acc = wr_valid && m_ready();
      if (flush) begin
        m_q.delete();
      end else begin
        if (l) void'(m_q.pop_front());
        if (acc) m_q.push_back(wr_data);
      end
      if (l) begin
        m_free     = 1'b0;
        m_seen_low = 1'b0;
        m_hi       = 0;
      end else if (!m_free) begin
        if (!m_seen_low) begin
          m_seen_low = !enc_avail;
        end else if (enc_avail) begin
          m_hi++;
          if (m_hi >= THR) m_free = 1'b1;
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [N_PKT-1:0] d, input bit av, input bit fl);
    @(negedge clk);
    wr_valid  = v;
    wr_data   = d;
    enc_avail = av;
    flush     = fl;
    #1;
  endtask

  task automatic settle();
    for (int i = 0; i < THR + 4; i++) begin
      drive(1'b0, '0, (i >= 2), 1'b0);
      checks++;
      if (enc_start !== m_launch()) begin
        errors++;
        $display("FAIL settle_start got %b want %b", enc_start, m_launch());
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_valid = 1'b0; flush = 1'b0; enc_avail = 1'b1;
    #12;
    checks++; if (enc_start !== 1'b0) begin errors++; $display("FAIL reset_enc_start got %b want 0", enc_start); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    drive(1'b1, 16'hA5A5, 1'b1, 1'b0);
    checks++; if (enc_start !== 1'b0) begin errors++; $display("FAIL single_push_cycle_start got %b want 0", enc_start); end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if (enc_start !== 1'b1) begin errors++; $display("FAIL single_start got %b want 1", enc_start); end
    checks++; if (enc_data !== 16'hA5A5) begin errors++; $display("FAIL single_data got %h want a5a5", enc_data); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count1 got %0d want 1", count); end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if (enc_start !== 1'b0) begin errors++; $display("FAIL single_one_pulse got %b want 0", enc_start); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count0 got %0d want 0", count); end
    settle();
  endtask

  task automatic test_fill();
    int busy = 0;
    int got = 0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 16'(i), 1'b0, 1'b0);
      checks++;
      if (wr_ready !== (i <= 4)) begin errors++; $display("FAIL fill_wr_ready_%0d got %b want %b", i, wr_ready, (i <= 4)); end
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", full); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", count); end
    for (int c = 0; c < 200 && got < 4; c++) begin
      drive(1'b0, '0, (busy == 0), 1'b0);
      if (enc_start === 1'b1) begin
        checks++;
        if (enc_data !== 16'(got + 1)) begin errors++; $display("FAIL fill_order got %h want %h", enc_data, 16'(got + 1)); end
        got++;
        busy = 2;
      end else if (busy > 0) begin
        busy--;
      end
    end
    checks++; if (got != 4) begin errors++; $display("FAIL fill_drain_timeout got %0d want 4", got); end
    settle();
  endtask

  task automatic test_gap_timing();
    int busy = 0;
    int starts = 0;
    int st0 = -1;
    int st1 = -1;
    int rise = -1;
    bit prev_av = 1'b1;
    bit av;
    drive(1'b1, 16'h1111, 1'b0, 1'b0);
    drive(1'b1, 16'h2222, 1'b0, 1'b0);
    for (int c = 0; c < 100 && starts < 2; c++) begin
      av = (busy == 0);
      drive(1'b0, '0, av, 1'b0);
      if (av && !prev_av && starts == 1) rise = c;
      prev_av = av;
      checks++;
      if (enc_start !== m_launch()) begin errors++; $display("FAIL gap_model_start cyc %0d got %b want %b", c, enc_start, m_launch()); end
      if (enc_start === 1'b1) begin
        if (starts == 0) st0 = c; else st1 = c;
        starts++;
        busy = 10;
      end else if (busy > 0) begin
        busy--;
      end
    end
    checks++; if (st1 - rise != 3) begin errors++; $display("FAIL gap_after_avail got %0d want 3", st1 - rise); end
    checks++; if (st1 - st0 != 14) begin errors++; $display("FAIL gap_start_spacing got %0d want 14", st1 - st0); end
    settle();
  endtask

  task automatic test_full_pop_flush();
    int hit = -1;
    for (int i = 0; i < 4; i++) drive(1'b1, 16'h000A + 16'(i), 1'b0, 1'b0);
    drive(1'b1, 16'h0055, 1'b1, 1'b0);
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL fullpop_wr_ready got %b want 0", wr_ready); end
    checks++; if (enc_start !== 1'b1) begin errors++; $display("FAIL fullpop_start got %b want 1", enc_start); end
    checks++; if (enc_data !== 16'h000A) begin errors++; $display("FAIL fullpop_data got %h want 000a", enc_data); end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fullpop_count got %0d want 3", count); end
    drive(1'b0, '0, 1'b1, 1'b1);
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL flush_wr_ready got %b want 0", wr_ready); end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %b want 1", empty); end
    drive(1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (enc_start !== 1'b0) begin errors++; $display("FAIL flush_no_start got %b want 0", enc_start); end
    drive(1'b1, 16'hBEEF, 1'b1, 1'b0);
    for (int c = 1; c < 20 && hit < 0; c++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      if (enc_start === 1'b1) begin
        hit = c;
        checks++;
        if (enc_data !== 16'hBEEF) begin errors++; $display("FAIL flush_beef_data got %h want beef", enc_data); end
      end
    end
    checks++; if (hit != 3) begin errors++; $display("FAIL flush_beef_delay got %0d want 3", hit); end
  endtask

  task automatic test_reset_mid_gap();
    int seen = 0;
    drive(1'b1, 16'h0101, 1'b1, 1'b0);
    drive(1'b1, 16'h0202, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL rgap_count_before got %0d want 2", count); end
    rst_n = 1'b0;
    #1;
    checks++; if (enc_start !== 1'b0) begin errors++; $display("FAIL rgap_enc_start got %b want 0", enc_start); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rgap_empty got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rgap_full got %b want 0", full); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rgap_wr_ready got %b want 1", wr_ready); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rgap_count got %0d want 0", count); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      if (enc_start === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rgap_stray_start got %0d want 0", seen); end
    drive(1'b1, 16'h3333, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if (enc_start !== 1'b1) begin errors++; $display("FAIL rgap_new_start got %b want 1", enc_start); end
    checks++; if (enc_data !== 16'h3333) begin errors++; $display("FAIL rgap_new_data got %h want 3333", enc_data); end
    settle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 31) == 0));
      checks++;
      if (enc_start !== m_launch()) begin errors++; $display("FAIL rnd_start cyc %0d got %b want %b", c, enc_start, m_launch()); end
      checks++;
      if (count !== 3'(m_q.size())) begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", c, count, m_q.size()); end
      checks++;
      if (wr_ready !== m_ready()) begin errors++; $display("FAIL rnd_wr_ready cyc %0d got %b want %b", c, wr_ready, m_ready()); end
      checks++;
      if ({full, empty} !== {(m_q.size() == DEPTH), (m_q.size() == 0)}) begin
        errors++;
        $display("FAIL rnd_flags cyc %0d got %b%b want %b%b", c, full, empty, (m_q.size() == DEPTH), (m_q.size() == 0));
      end
      if (m_launch()) begin
        checks++;
        if (enc_data !== m_q[0]) begin errors++; $display("FAIL rnd_data cyc %0d got %h want %h", c, enc_data, m_q[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_gap_timing();
    test_full_pop_flush();
    test_reset_mid_gap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_packet_queue.md
TX_PACKET_QUEUE -- requirements
Module: tx_packet_queue

Interface
REQ-001 Parameter N_PKT, default 16: packet width in bits; must equal the OPPM encoder's packet width.
REQ-002 Parameter DEPTH, default 4: queue capacity in packets; power of two, >= 2.
REQ-003 Parameter GAP_CT, default 8: minimum idle clock ticks between successive encoder launches; >= 0.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 wr_data  input  N_PKT  packet to enqueue.
REQ-007 wr_valid  input  1  wr_data is valid this cycle.
REQ-008 wr_ready  output  1  queue accepts a packet this cycle.
REQ-009 flush  input  1  synchronous discard of all queued packets.
REQ-010 enc_avail  input  1  encoder idle and able to latch a packet.
REQ-011 enc_start  output  1  one-cycle launch strobe to the encoder.
REQ-012 enc_data  output  N_PKT  packet presented to the encoder; valid whenever enc_start=1.
REQ-013 count  output  $clog2(DEPTH+1)  number of queued packets.
REQ-014 empty, full  output  1 each  count==0, count==DEPTH.

Function
REQ-015 Push occurs when wr_valid && wr_ready; wr_ready = ~full && ~flush; no same-cycle pass-through when full, even if a pop occurs that cycle.
REQ-016 Storage is a circular buffer; read and write pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0 without extra logic.
REQ-017 enc_data is driven from the head entry combinationally; its value is a don't-care when empty.
REQ-018 The FSM has three states: IDLE, LAUNCH, GAP.
REQ-019 IDLE: when enc_avail && ~empty && ~flush, assert enc_start for one cycle, pop the head, and go to LAUNCH; otherwise remain in IDLE.
REQ-020 LAUNCH: enc_start=0; wait for enc_avail=0 (encoder has left idle); then clear the gap counter and go to GAP.
REQ-021 GAP: wait for enc_avail=1, then count GAP_CT further cycles; return to IDLE when the count reaches GAP_CT. With GAP_CT=0, return to IDLE on the first cycle enc_avail=1.
REQ-022 A packet pushed into an empty queue produces enc_start no earlier than the next cycle.
REQ-023 Push and pop in the same cycle leave count unchanged; both pointers advance.
REQ-024 flush clears pointers and count next cycle; flush has priority over push and pop in that cycle; FSM state and the in-flight encoder transfer are unaffected.
REQ-025 enc_start is never asserted in two consecutive cycles and is never asserted while empty.

Reset
REQ-026 Asynchronous reset: state=IDLE, pointers=0, count=0, gap counter=0.
REQ-027 Output values during reset: enc_start=0, empty=1, full=0, wr_ready=1.
REQ-028 Storage array contents are not reset.
REQ-029 Reset asserted mid-launch discards all queued packets; the first enc_start after release requires a new push.

Structure
REQ-030 The state enum {IDLE, LAUNCH, GAP} resides in shared package oppm_pkg with the other OPPM link enums.
REQ-031 Storage and pointer logic is a sub-module, packet_fifo (push, pop, flush, head, count), reusable on the receive side.
REQ-032 The FSM and gap counter reside in tx_packet_queue; the gap counter uses the team's existing Counter module.

Verification
All scenarios use N_PKT=16, DEPTH=4, GAP_CT=3 unless stated.
REQ-033 Push 0xA5A5 with enc_avail=1 held -> enc_start is a single pulse one cycle later with enc_data=0xA5A5; count goes 1 then 0.
REQ-034 Push 0x0001..0x0005 back-to-back with enc_avail=0 -> first four are accepted, wr_ready=0 on the fifth, full=1, count=4; pops later yield 0x0001..0x0004 in order.
REQ-035 Queue holding 2 packets; encoder model drops avail for 10 cycles after each start -> second enc_start occurs exactly 3 cycles after avail returns high.
REQ-036 Queue full, simultaneous wr_valid and pop -> push rejected; count goes 4 to 3.
REQ-037 flush asserted with count=3 during LAUNCH -> count=0 and empty=1 next cycle; no further enc_start; a new push of 0xBEEF launches after the gap.
REQ-038 rst_n pulsed low mid-GAP with count=2 -> all outputs at reset values; no enc_start until a new push.
